// File: rtl/stage_block_gen_pkg.sv
// Shared stage definitions: block record layout, stat bit meanings, generator
// FSM states and the LFSR step used by the procedural stage generator.
package stage_block_gen_pkg;

  localparam int POS_W  = 16;
  localparam int STAT_W = 4;
  localparam int BLK_W  = 3 * POS_W + STAT_W;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // On-wire block record, MSB first: {left, right, height, stat}
  typedef struct packed {
    logic [POS_W-1:0]  left;
    logic [POS_W-1:0]  right;
    logic [POS_W-1:0]  height;
    logic [STAT_W-1:0] stat;
  } stage_blk_t;

  typedef enum logic [1:0] {
    STAT_CEIL = 2'd0,
    STAT_RSV1 = 2'd1,
    STAT_RSV2 = 2'd2,
    STAT_RSV3 = 2'd3
  } stat_bit_e;

  localparam int STAT_CEIL_IDX = int'(STAT_CEIL);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FIRST = 3'd1,
    ST_GEN   = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Galois right shift; the mask is folded in when the shifted-out bit is 1
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

endpackage

// File: rtl/stage_block_gen_lfsr.sv
// 16-bit Galois LFSR: reloads its seed on rst, advances one step when step=1.
module lfsr16_galois
  import stage_block_gen_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [15:0] value
);

  // An all-zero seed would lock the register at zero forever
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= SEED_EFF;
    end else if (step) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/stage_block_gen.sv
// Procedural stage generator: emits {left, right, height, stat} block records in
// increasing map-x order, one per valid/ready transfer, until the map end.
module stage_block_gen
  import stage_block_gen_pkg::*;
#(
  parameter int          POS_DIGIT = 16,
  parameter int          V_RES     = 600,
  parameter int          MAP_END   = 10000,
  parameter int          START_LEN = 400,
  parameter int          FLOOR_H   = 100,
  parameter int          MIN_GAP   = 64,
  parameter int          G_STEP    = 16,
  parameter int          MIN_W     = 96,
  parameter int          W_STEP    = 16,
  parameter int          MIN_H     = 64,
  parameter int          H_STEP    = 16,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                     i_clk_pix,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [3*POS_DIGIT+3:0]   o_blk,
  output logic [15:0]              o_count,
  output logic                     o_done,
  output state_e                   dbg_state
);

  localparam int AW = POS_DIGIT + 1;
  localparam int BW = 3 * POS_DIGIT + 4;

  // Handshake: a transfer happens on a clock edge where o_valid && i_ready;
  // o_blk is frozen while o_valid is high and only a transfer lowers o_valid.

  state_e              state_q, state_d;
  logic                load_first, load_gen, xfer;
  logic [15:0]         lfsr_q, r;
  logic [BW-1:0]       blk_q;
  logic [POS_DIGIT-1:0] prev_r_q;
  logic                first_q;
  logic [15:0]         count_q;

  logic [AW-1:0] gap, width, left_c, right_c, h_raw, height_c;
  logic          overflow, ceil_c;
  logic [BW-1:0] gen_blk, first_blk;
  logic          unused_bits;

  lfsr16_galois #(.SEED(SEED)) u_lfsr (
    .clk   (i_clk_pix),
    .rst   (i_rst),
    .step  (state_q == ST_GEN),
    .value (lfsr_q)
  );

  // r is the value the LFSR takes on at the end of this GEN cycle
  assign r           = lfsr_next(lfsr_q);
  assign unused_bits = ^r[13:12];

  assign gap      = AW'(MIN_GAP) + AW'(r[3:0]) * AW'(G_STEP);
  assign width    = AW'(MIN_W) + AW'(r[7:4]) * AW'(W_STEP);
  assign left_c   = {1'b0, prev_r_q} + AW'(1) + gap;
  assign right_c  = left_c + width - AW'(1);
  assign overflow = right_c > AW'(MAP_END);
  assign h_raw    = AW'(MIN_H) + AW'(r[11:8]) * AW'(H_STEP);
  assign height_c = (h_raw > AW'(V_RES - 1)) ? AW'(V_RES - 1) : h_raw;

  // While in GEN, blk_q still holds the block that was just transferred
  assign ceil_c   = (r[15:14] == 2'b11) && !blk_q[STAT_CEIL_IDX] && !first_q;

  assign gen_blk   = {left_c[POS_DIGIT-1:0], right_c[POS_DIGIT-1:0],
                      height_c[POS_DIGIT-1:0], 3'b000, ceil_c};
  assign first_blk = {POS_DIGIT'(0), POS_DIGIT'(START_LEN - 1),
                      POS_DIGIT'(FLOOR_H), 4'h0};

  always_comb begin
    state_d    = state_q;
    load_first = 1'b0;
    load_gen   = 1'b0;
    xfer       = 1'b0;
    case (state_q)
      ST_IDLE:  if (i_start) state_d = ST_FIRST;
      ST_FIRST: begin
        load_first = 1'b1;
        state_d    = ST_HOLD;
      end
      ST_GEN: begin
        if (overflow) begin
          state_d = ST_DONE;
        end else begin
          load_gen = 1'b1;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (i_ready) begin
          xfer    = 1'b1;
          state_d = ST_GEN;
        end
      end
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_pix) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      blk_q    <= '0;
      prev_r_q <= '0;
      first_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_first) begin
        blk_q   <= first_blk;
        first_q <= 1'b1;
        count_q <= '0;
      end
      if (load_gen) begin
        blk_q   <= gen_blk;
        first_q <= 1'b0;
      end
      if (xfer) begin
        count_q  <= count_q + 16'd1;
        prev_r_q <= blk_q[POS_DIGIT+4 +: POS_DIGIT];
      end
    end
  end

  assign o_valid   = (state_q == ST_HOLD);
  assign o_done    = (state_q == ST_DONE);
  assign o_blk     = blk_q;
  assign o_count   = count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_stage_block_gen.sv
// Directed bench for stage_block_gen: reset, first blocks, stalls, free run,
// short map end with height clamp, and reset/restart repeatability.
module tb_stage_block_gen;
  import stage_block_gen_pkg::*;

  localparam int BW = 52;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, ready = 1'b0;

  logic          o_valid, o_done;
  logic [BW-1:0] o_blk;
  logic [15:0]   o_count;
  state_e        dbg_state;

  logic          s_valid, s_done;
  logic [BW-1:0] s_blk;
  logic [15:0]   s_count;
  state_e        s_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [BW-1:0] exp_q[$];

  stage_block_gen dut (
    .i_clk_pix (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_ready   (ready),
    .o_valid   (o_valid),
    .o_blk     (o_blk),
    .o_count   (o_count),
    .o_done    (o_done),
    .dbg_state (dbg_state)
  );

  stage_block_gen #(.MAP_END(700), .V_RES(90)) dut_short (
    .i_clk_pix (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_ready   (ready),
    .o_valid   (s_valid),
    .o_blk     (s_blk),
    .o_count   (s_count),
    .o_done    (s_done),
    .dbg_state (s_state)
  );

  // ---------------- clock / reset ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [BW-1:0] mk_blk(input int l, input int rr, input int h, input int s);
    return {16'(l), 16'(rr), 16'(h), 4'(s)};
  endfunction

  function automatic logic [15:0] model_step(input logic [15:0] v);
    logic [15:0] sh;
    sh = {1'b0, v[15:1]};
    if (v[0]) sh = sh ^ 16'hB400;
    return sh;
  endfunction

  task automatic build_expected(input int map_end, input int v_res);
    logic [15:0] lf;
    int pr, left, right, h;
    bit pc, pf, c;
    exp_q.delete();
    lf = 16'hACE1;
    exp_q.push_back(mk_blk(0, 399, 100, 0));
    pr = 399; pc = 1'b0; pf = 1'b1;
    forever begin
      lf    = model_step(lf);
      left  = pr + 1 + 64 + 16 * int'(lf[3:0]);
      right = left + 96 + 16 * int'(lf[7:4]) - 1;
      if (right > map_end) break;
      h = 64 + 16 * int'(lf[11:8]);
      if (h > v_res - 1) h = v_res - 1;
      c = (lf[15:14] == 2'b11) && !pc && !pf;
      exp_q.push_back(mk_blk(left, right, h, int'(c)));
      pr = right; pc = c; pf = 1'b0;
    end
  endtask

  // Streams blocks with ready=1, scoring each against exp_q; stop_at>=0 returns
  // while block stop_at is offered but before it is taken.
  task automatic run_stream(input string tag, input int stop_at);
    int n = 0;
    int cyc = 0;
    int last_r = -1;
    bit last_c = 1'b0;
    logic [BW-1:0] got;
    while (o_done !== 1'b1 && cyc < 3000) begin
      if (o_valid === 1'b1) begin
        if (n == stop_at) return;
        got = o_blk;
        n_checks++;
        if (n >= exp_q.size()) begin
          n_fail++;
          $display("FAIL %s extra_block idx=%0d got=%h", tag, n, got);
        end else if (got !== exp_q[n]) begin
          n_fail++;
          $display("FAIL %s blk[%0d] got=%h exp=%h", tag, n, got, exp_q[n]);
        end
        if (n > 0) begin
          n_checks++;
          if (!(int'(got[51:36]) > last_r)) begin
            n_fail++;
            $display("FAIL %s order idx=%0d left=%0d prev_right=%0d", tag, n, got[51:36], last_r);
          end
          n_checks++;
          if (got[0] && last_c) begin
            n_fail++;
            $display("FAIL %s ceil_pair idx=%0d got=1 exp=0", tag, n);
          end
        end
        n_checks++;
        if (int'(got[35:20]) > 10000) begin
          n_fail++;
          $display("FAIL %s map_end idx=%0d right=%0d limit=10000", tag, n, got[35:20]);
        end
        last_r = int'(got[35:20]);
        last_c = got[0];
        n++;
      end
      tick();
      cyc++;
    end
    if (stop_at >= 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s stop_point got=%0d blocks exp>%0d", tag, n, stop_at);
      return;
    end
    n_checks++;
    if (o_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done_timeout got=%b exp=1", tag, o_done);
    end
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s valid_after_done got=%b exp=0", tag, o_valid);
    end
    n_checks++;
    if (o_count !== 16'(n)) begin
      n_fail++;
      $display("FAIL %s count got=%0d exp=%0d", tag, o_count, n);
    end
    n_checks++;
    if (n != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s total got=%0d exp=%0d", tag, n, exp_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if (o_valid !== 1'b0 || o_done !== 1'b0 || o_count !== 16'd0 || o_blk !== '0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_values got=%b/%b/%0d/%h/%0d exp=0/0/0/0/IDLE", o_valid, o_done, o_count, o_blk, dbg_state);
    end
    ready = 1'b1;
    repeat (10) tick();
    n_checks++;
    if (o_valid !== 1'b0 || o_done !== 1'b0 || o_count !== 16'd0) begin
      n_fail++;
      $display("FAIL idle_no_start got=%b/%b/%0d exp=0/0/0", o_valid, o_done, o_count);
    end
    ready = 1'b0;
  endtask

  task automatic test_first_blocks();
    do_reset();
    ready = 1'b1;
    pulse_start();
    n_checks++;
    if (dbg_state !== ST_FIRST || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL first_state got=%0d/%b exp=FIRST/0", dbg_state, o_valid);
    end
    tick();
    n_checks++;
    if (o_valid !== 1'b1 || o_blk !== mk_blk(0, 399, 100, 0) || o_count !== 16'd0) begin
      n_fail++;
      $display("FAIL block0 got=%b/%h/%0d exp=1/%h/0", o_valid, o_blk, o_count, mk_blk(0, 399, 100, 0));
    end
    tick();
    n_checks++;
    if (o_valid !== 1'b0 || o_count !== 16'd1 || dbg_state !== ST_GEN) begin
      n_fail++;
      $display("FAIL after_xfer0 got=%b/%0d/%0d exp=0/1/GEN", o_valid, o_count, dbg_state);
    end
    tick();
    n_checks++;
    if (o_valid !== 1'b1 || o_blk !== mk_blk(464, 671, 96, 0)) begin
      n_fail++;
      $display("FAIL block1 got=%b/%h exp=1/%h", o_valid, o_blk, mk_blk(464, 671, 96, 0));
    end
    ready = 1'b0;
  endtask

  task automatic test_hold_stall();
    int bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (o_valid !== 1'b1 || o_blk !== mk_blk(464, 671, 96, 0) || o_count !== 16'd1) begin
        n_fail++;
        bad++;
        if (bad < 4) $display("FAIL stall cyc=%0d got=%b/%h/%0d exp=1/%h/1", i, o_valid, o_blk, o_count, mk_blk(464, 671, 96, 0));
      end
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    n_checks++;
    if (o_valid !== 1'b0 || o_count !== 16'd2) begin
      n_fail++;
      $display("FAIL release got=%b/%0d exp=0/2", o_valid, o_count);
    end
    tick();
    n_checks++;
    if (o_valid !== 1'b1 || o_blk !== mk_blk(864, 1007, 80, 0) || o_count !== 16'd2) begin
      n_fail++;
      $display("FAIL block2 got=%b/%h/%0d exp=1/%h/2", o_valid, o_blk, o_count, mk_blk(864, 1007, 80, 0));
    end
    repeat (3) tick();
    n_checks++;
    if (o_valid !== 1'b1 || o_count !== 16'd2) begin
      n_fail++;
      $display("FAIL single_xfer got=%b/%0d exp=1/2", o_valid, o_count);
    end
  endtask

  task automatic test_free_run();
    do_reset();
    build_expected(10000, 600);
    ready = 1'b1;
    pulse_start();
    run_stream("free_run", -1);
    ready = 1'b0;
  endtask

  task automatic test_map_end();
    int n = 0;
    int cyc = 0;
    do_reset();
    ready = 1'b1;
    pulse_start();
    while (s_done !== 1'b1 && cyc < 100) begin
      if (s_valid === 1'b1) begin
        if (n == 0) begin
          n_checks++;
          if (s_blk !== mk_blk(0, 399, 100, 0)) begin
            n_fail++;
            $display("FAIL short_blk0 got=%h exp=%h", s_blk, mk_blk(0, 399, 100, 0));
          end
        end else if (n == 1) begin
          n_checks++;
          if (s_blk !== mk_blk(464, 671, 89, 0)) begin
            n_fail++;
            $display("FAIL short_blk1_clamp got=%h exp=%h", s_blk, mk_blk(464, 671, 89, 0));
          end
        end
        n++;
      end
      tick();
      cyc++;
    end
    n_checks++;
    if (s_done !== 1'b1 || s_valid !== 1'b0 || s_count !== 16'd2 || n != 2) begin
      n_fail++;
      $display("FAIL short_done got=%b/%b/%0d/%0d exp=1/0/2/2", s_done, s_valid, s_count, n);
    end
    ready = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (s_done !== 1'b1 || s_count !== 16'd2) begin
      n_fail++;
      $display("FAIL short_done_sticky got=%b/%0d exp=1/2", s_done, s_count);
    end
  endtask

  task automatic test_reset_rerun();
    do_reset();
    build_expected(10000, 600);
    ready = 1'b1;
    pulse_start();
    run_stream("pre_reset", 2);
    rst   = 1'b1;
    start = 1'b1;
    tick();
    n_checks++;
    if (o_valid !== 1'b0 || o_count !== 16'd0 || dbg_state !== ST_IDLE || o_blk !== '0) begin
      n_fail++;
      $display("FAIL mid_hold_reset got=%b/%0d/%0d/%h exp=0/0/IDLE/0", o_valid, o_count, dbg_state, o_blk);
    end
    rst   = 1'b0;
    start = 1'b0;
    tick();
    n_checks++;
    if (dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL start_under_reset got=%0d exp=IDLE", dbg_state);
    end
    pulse_start();
    run_stream("rerun", -1);
    ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_blocks();
    test_hold_stall();
    test_free_run();
    test_map_end();
    test_reset_rerun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
